// File: rtl/adsr_env.sv
// adsr_env: gate-driven linear ADSR envelope applied to a signed sample stream
// Ports:
//   i_clk, i_reset_n (async, active low)
//   i_in_ready       sample strobe; the only cycle on which state/env/output update
//   i_gate           note on/off, sampled on strobes
//   i_sample_in      signed input sample
//   i_attack_step, i_decay_step, i_release_step  per-sample rates (0 = instant)
//   i_sustain_level  sustain target
//   o_sample_out     registered sample_in * env >>> ENV_WIDTH
//   o_out_valid      one-cycle pulse after each strobe
//   o_env_level, o_env_state, o_busy  envelope status
module adsr_env #(
  parameter int WIDTH      = 16,
  parameter int ENV_WIDTH  = 16,
  parameter int RATE_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_in_ready,
  input  logic                         i_gate,
  input  logic signed [WIDTH-1:0]      i_sample_in,
  input  logic        [RATE_WIDTH-1:0] i_attack_step,
  input  logic        [RATE_WIDTH-1:0] i_decay_step,
  input  logic        [ENV_WIDTH-1:0]  i_sustain_level,
  input  logic        [RATE_WIDTH-1:0] i_release_step,
  output logic signed [WIDTH-1:0]      o_sample_out,
  output logic                         o_out_valid,
  output logic        [ENV_WIDTH-1:0]  o_env_level,
  output logic        [2:0]            o_env_state,
  output logic                         o_busy
);
  localparam int EXT = ENV_WIDTH + 1;
  localparam int PW  = WIDTH + ENV_WIDTH + 1;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;
  state_t                   r_state, w_next_state;
  logic [ENV_WIDTH-1:0]     r_env, w_next_env;
  logic signed [WIDTH-1:0]  r_sample_out;
  logic                     r_out_valid;
  logic [EXT-1:0]           w_env_x, w_att_x, w_dec_x, w_rel_x, w_sus_x, w_att_sum;
  logic                     w_att_full, w_dec_done, w_rel_done, w_go_attack, w_go_release;
  logic signed [PW-1:0]     w_samp_s, w_env_s, w_prod;
  // Stepping is one bit wider than the envelope so overflow is visible before saturation
  assign w_env_x   = {1'b0, r_env};
  assign w_att_x   = EXT'(i_attack_step);
  assign w_dec_x   = EXT'(i_decay_step);
  assign w_rel_x   = EXT'(i_release_step);
  assign w_sus_x   = {1'b0, i_sustain_level};
  assign w_att_sum = w_env_x + w_att_x;
  assign w_att_full = (i_attack_step == '0) || (w_att_sum >= {1'b0, ENV_MAX});
  // env - step <= sustain rewritten as env - sustain <= step; only meaningful when env > sustain
  assign w_dec_done = (i_decay_step == '0) || (w_env_x <= w_sus_x) || (w_env_x - w_sus_x <= w_dec_x);
  assign w_rel_done = (i_release_step == '0) || (w_env_x <= w_rel_x);
  assign w_go_attack  = i_gate && (r_state == S_IDLE || r_state == S_ATTACK || r_state == S_RELEASE);
  assign w_go_release = !i_gate && (r_state == S_ATTACK || r_state == S_DECAY || r_state == S_SUSTAIN);
  always_comb begin
    w_next_state = r_state;
    w_next_env   = r_env;
    if (w_go_attack) begin
      w_next_state = w_att_full ? S_DECAY : S_ATTACK;
      w_next_env   = w_att_full ? ENV_MAX : ENV_WIDTH'(w_att_sum);
    end else if (w_go_release) begin
      w_next_state = S_RELEASE;
    end else begin
      case (r_state)
        S_IDLE:    w_next_env = '0;
        S_DECAY: begin
          w_next_state = w_dec_done ? S_SUSTAIN : S_DECAY;
          w_next_env   = w_dec_done ? i_sustain_level : ENV_WIDTH'(w_env_x - w_dec_x);
        end
        S_SUSTAIN: w_next_env = i_sustain_level;
        S_RELEASE: begin
          w_next_state = w_rel_done ? S_IDLE : S_RELEASE;
          w_next_env   = w_rel_done ? '0 : ENV_WIDTH'(w_env_x - w_rel_x);
        end
        default: ;
      endcase
    end
  end
  // Envelope is zero-extended so it multiplies as a non-negative signed value
  assign w_samp_s = {{(ENV_WIDTH+1){i_sample_in[WIDTH-1]}}, i_sample_in};
  assign w_env_s  = {{WIDTH{1'b0}}, w_env_x};
  assign w_prod   = w_samp_s * w_env_s;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_env        <= '0;
      r_sample_out <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= i_in_ready;
      if (i_in_ready) begin
        r_state      <= w_next_state;
        r_env        <= w_next_env;
        r_sample_out <= w_prod[ENV_WIDTH+WIDTH-1:ENV_WIDTH];
      end
    end
  end
  assign o_sample_out = r_sample_out;
  assign o_out_valid  = r_out_valid;
  assign o_env_level  = r_env;
  assign o_env_state  = r_state;
  assign o_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: vector table, corner sequences and randomized run against a reference model
module tb_adsr_env;
  localparam int MAX = 65535;
  logic clk = 1'b0;
  logic rst_n, in_ready, gate;
  logic signed [15:0] sample_in;
  logic [15:0] a_step, d_step, sus, r_step;
  logic signed [15:0] sample_out;
  logic out_valid, busy;
  logic [15:0] env_level;
  logic [2:0] env_state;
  int n_chk = 0, n_fail = 0;
  int m_env, m_st, m_out;
  typedef struct {
    bit g;
    int s, a, d, sus, r, env, st, out;
  } vec_t;
  vec_t tv[$];
  adsr_env #(.WIDTH(16), .ENV_WIDTH(16), .RATE_WIDTH(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_in_ready(in_ready), .i_gate(gate),
    .i_sample_in(sample_in), .i_attack_step(a_step), .i_decay_step(d_step),
    .i_sustain_level(sus), .i_release_step(r_step), .o_sample_out(sample_out),
    .o_out_valid(out_valid), .o_env_level(env_level), .o_env_state(env_state), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic scramble();
    gate      = 1'($urandom);
    sample_in = 16'($urandom);
    a_step    = 16'($urandom);
    d_step    = 16'($urandom);
    sus       = 16'($urandom);
    r_step    = 16'($urandom);
  endtask
  task automatic strobe(input bit g, input int s, input int a, input int d, input int su, input int r);
    @(negedge clk);
    gate = g; sample_in = 16'(s); a_step = 16'(a); d_step = 16'(d); sus = 16'(su); r_step = 16'(r);
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    scramble();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_ready = 1'(i & 1);
      gate = 1'b1; a_step = 16'd1000;
      @(posedge clk);
      #1;
    end
    check("rst_out", sample_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_state", env_state, 0);
    check("rst_env", env_level, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    in_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", env_state, 0);
    m_env = 0; m_st = 0; m_out = 0;
  endtask
  // Reference: direct rendering of the segment rules with integer arithmetic
  task automatic model(input bit g, input int s, input int a, input int d, input int su, input int r);
    longint p;
    bit att;
    p = longint'(s) * longint'(m_env);
    m_out = int'(p >>> 16);
    att = 0;
    if (m_st == 0) begin
      if (g) att = 1; else m_env = 0;
    end else if (m_st == 1 || m_st == 2 || m_st == 3) begin
      if (!g) m_st = 4;
      else if (m_st == 1) att = 1;
      else if (m_st == 2) begin
        if (d == 0 || m_env <= su || m_env - d <= su) begin m_env = su; m_st = 3; end
        else m_env = m_env - d;
      end else m_env = su;
    end else begin
      if (g) att = 1;
      else if (r == 0 || m_env <= r) begin m_env = 0; m_st = 0; end
      else m_env = m_env - r;
    end
    if (att) begin
      if (a == 0 || m_env + a >= MAX) begin m_env = MAX; m_st = 2; end
      else begin m_env = m_env + a; m_st = 1; end
    end
  endtask
  initial begin
    int g_r, a_r, d_r, su_r, r_r, s_r;
    rst_n = 1'b1; in_ready = 1'b0;
    scramble();
    //        g  sample  att    dec   sus    rel    env    st  out
    tv.push_back('{1, 16384, 16384, 8192, 40000, 10000, 16384, 1, 0});
    tv.push_back('{1, 16384, 16384, 8192, 40000, 10000, 32768, 1, 4096});
    tv.push_back('{0, 16384, 16384, 8192, 40000, 10000, 32768, 4, 8192});
    tv.push_back('{0, 16384, 16384, 8192, 40000, 10000, 22768, 4, 8192});
    tv.push_back('{1, -1,    16384, 8192, 40000, 10000, 39152, 1, -1});
    tv.push_back('{1, -32768,16384, 8192, 40000, 10000, 55536, 1, -19576});
    tv.push_back('{1, 0,     16384, 8192, 40000, 10000, 65535, 2, 0});
    tv.push_back('{1, -32768,16384, 8192, 40000, 10000, 57343, 2, -32768});
    tv.push_back('{1, 16384, 16384, 8192, 40000, 10000, 49151, 2, 14335});
    tv.push_back('{1, 100,   16384, 8192, 40000, 10000, 40959, 2, 74});
    tv.push_back('{1, 0,     16384, 8192, 40000, 10000, 40000, 3, 0});
    tv.push_back('{1, -1,    16384, 8192, 30000, 10000, 30000, 3, -1});
    tv.push_back('{0, 32767, 16384, 8192, 30000, 10000, 30000, 4, 14999});
    tv.push_back('{0, 0,     16384, 8192, 30000, 10000, 20000, 4, 0});
    tv.push_back('{0, 0,     16384, 8192, 30000, 10000, 10000, 4, 0});
    tv.push_back('{0, 32767, 16384, 8192, 30000, 10000, 0,     0, 4999});
    tv.push_back('{1, 0,     0,     8192, 30000, 10000, 65535, 2, 0});
    tv.push_back('{1, 32767, 0,     8192, 65535, 10000, 65535, 3, 32766});
    tv.push_back('{1, 0,     0,     8192, 0,     10000, 0,     3, 0});
    tv.push_back('{1, 0,     0,     8192, 0,     10000, 0,     3, 0});
    tv.push_back('{0, 0,     0,     8192, 0,     0,     0,     4, 0});
    tv.push_back('{0, 0,     0,     8192, 0,     0,     0,     0, 0});
    do_reset();
    foreach (tv[i]) begin
      strobe(tv[i].g, tv[i].s, tv[i].a, tv[i].d, tv[i].sus, tv[i].r);
      check($sformatf("vec%0d_env", i), env_level, tv[i].env);
      check($sformatf("vec%0d_state", i), env_state, tv[i].st);
      check($sformatf("vec%0d_out", i), sample_out, tv[i].out);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_busy", i), busy, tv[i].st != 0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_drop", i), out_valid, 0);
      check($sformatf("vec%0d_hold", i), env_level, tv[i].env);
    end
    // Reset mid-note: outputs clear without waiting for a clock edge
    strobe(1, 30000, 1000, 0, 0, 0);
    strobe(1, 30000, 1000, 0, 0, 0);
    check("pre_abort_env", env_level, 2000);
    check("pre_abort_out", sample_out, 457);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_env", env_level, 0);
    check("abort_state", env_state, 0);
    check("abort_out", sample_out, 0);
    check("abort_busy", busy, 0);
    do_reset();
    // Randomized run; gate and other inputs are scrambled between strobes and must be ignored
    g_r = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) g_r = 1 - g_r;
      s_r  = int'($urandom_range(0, 65535)) - 32768;
      a_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25000));
      d_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25000));
      r_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25000));
      su_r = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? MAX : 0) : int'($urandom_range(0, MAX));
      model(g_r[0], s_r, a_r, d_r, su_r, r_r);
      strobe(g_r[0], s_r, a_r, d_r, su_r, r_r);
      check("rnd_env", env_level, m_env);
      check("rnd_state", env_state, m_st);
      check("rnd_out", sample_out, m_out);
      check("rnd_valid", out_valid, 1);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk);
        #1;
        scramble();
        check("rnd_gap_valid", out_valid, 0);
        check("rnd_gap_env", env_level, m_env);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
